// File: rtl/gate_sweep_ctrl_pkg.sv
// Shared definitions for the gate sweep checker.
//   - FSM state encodings (legacy values kept as localparams, wrapped by state_t)
//   - VEC_COUNT: number of {a,b} input vectors of a 2-input gate
//   - TRUTH_* : expected-output tables indexed by {a,b} (bit3=11 ... bit0=00)
//   - truth_bit(): expected y for a given table and vector
package gate_sweep_ctrl_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    DRIVE  = ST_DRIVE,
    SAMPLE = ST_SAMPLE,
    DONE   = ST_DONE
  } state_t;

  localparam int unsigned VEC_COUNT = 4;

  localparam logic [3:0] TRUTH_AND  = 4'b1000;
  localparam logic [3:0] TRUTH_OR   = 4'b1110;
  localparam logic [3:0] TRUTH_XOR  = 4'b0110;
  localparam logic [3:0] TRUTH_NAND = 4'b0111;

  function automatic logic truth_bit(input logic [3:0] table_v, input logic [1:0] vec);
    return table_v[vec];
  endfunction

endpackage

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// sweep_settle_timer: settle-time down counter for the gate sweep FSM.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   load   : reload the counter (asserted on the edge that enters DRIVE)
//   run    : FSM is in DRIVE; counting enabled
//   expire : high in the last DRIVE cycle, i.e. SETTLE_CYCLES cycles after load
module sweep_settle_timer #(
  parameter int unsigned W             = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expire
);

  logic [W-1:0] count;

  // Loaded with SETTLE_CYCLES-1 so that expire is seen in the
  // SETTLE_CYCLES-th DRIVE cycle and the FSM leaves on the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= W'(SETTLE_CYCLES - 1);
    end else if (run && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expire = run && (count == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: on-chip self-test sequencer for a 2-input combinational gate.
// Drives all four {a,b} vectors, waits SETTLE_CYCLES, samples y_i and compares
// against TRUTH. Repeats the sweep REPEAT times per accepted start.
// Ports:
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   start     : sweep request, sampled only in IDLE
//   a_o, b_o  : registered gate inputs
//   y_i       : gate output under test (sampled only in SAMPLE)
//   busy      : high from the start-accept edge until DONE exits
//   done      : one-cycle end-of-run pulse
//   pass      : no mismatch in last run; held until next accepted start
//   fail_idx  : {a,b} of first mismatch in last run (0 when pass)
//   err_cnt   : saturating mismatch count, only with GATE_SWEEP_ERRCNT_EN
// Optional feature macro: GATE_SWEEP_ERRCNT_EN
module gate_sweep_ctrl
  import gate_sweep_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  TRUTH         = TRUTH_AND,
  parameter int unsigned REPEAT        = 1,
  parameter int unsigned CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  input  logic             y_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_idx
`ifdef GATE_SWEEP_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  state_t           state, state_nx;
  logic [1:0]       vec;
  logic [CNT_W-1:0] sweep;
  logic             flag;
  logic             settle_exp;
  logic             timer_load;
  logic             mismatch;
  logic             last_vec;
  logic             last_sweep;

  assign last_vec   = (vec == 2'(VEC_COUNT - 1));
  assign last_sweep = (sweep == CNT_W'(REPEAT - 1));
  assign mismatch   = (state == SAMPLE) && (y_i != truth_bit(TRUTH, vec));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = DRIVE;
      DRIVE:   if (settle_exp) state_nx = SAMPLE;
      SAMPLE:  state_nx = (last_vec && last_sweep) ? DONE : DRIVE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign timer_load = (state != DRIVE) && (state_nx == DRIVE);

  sweep_settle_timer #(
    .W             (CNT_W),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .run    (state == DRIVE),
    .expire (settle_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      vec      <= '0;
      sweep    <= '0;
      flag     <= 1'b0;
      a_o      <= 1'b0;
      b_o      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_idx <= '0;
`ifdef GATE_SWEEP_ERRCNT_EN
      err_cnt  <= '0;
`endif
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            vec      <= '0;
            sweep    <= '0;
            flag     <= 1'b0;
            busy     <= 1'b1;
            pass     <= 1'b0;
            fail_idx <= '0;
            a_o      <= 1'b0;
            b_o      <= 1'b0;
`ifdef GATE_SWEEP_ERRCNT_EN
            err_cnt  <= '0;
`endif
          end
        end
        DRIVE: ;
        SAMPLE: begin
          if (mismatch && !flag) begin
            fail_idx <= vec;
            flag     <= 1'b1;
          end
`ifdef GATE_SWEEP_ERRCNT_EN
          if (mismatch && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
`endif
          if (!last_vec) begin
            vec        <= vec + 2'd1;
            {a_o, b_o} <= vec + 2'd1;
          end else if (!last_sweep) begin
            vec        <= '0;
            sweep      <= sweep + CNT_W'(1);
            {a_o, b_o} <= 2'b00;
          end else begin
            // Verdict is registered on DONE entry so pass/fail_idx are
            // already valid while done is high; includes this final sample.
            done       <= 1'b1;
            pass       <= ~(flag | mismatch);
            {a_o, b_o} <= 2'b00;
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
module tb_gate_sweep_ctrl;

  localparam logic [3:0] EXP_TT = 4'b1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] gate_tt;
  int         sel;

  logic       a0, b0, y0, busy0, done0, pass0, start0;
  logic       a1, b1, y1, busy1, done1, pass1, start1;
  logic [1:0] fi0, fi1;
`ifdef GATE_SWEEP_ERRCNT_EN
  logic [3:0] ec0, ec1;
`endif

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  assign y0     = gate_tt[{a0, b0}];
  assign y1     = gate_tt[{a1, b1}];
  assign start0 = (sel == 0) ? start : 1'b0;
  assign start1 = (sel == 1) ? start : 1'b0;

  gate_sweep_ctrl #(
    .SETTLE_CYCLES (2),
    .TRUTH         (4'b1000),
    .REPEAT        (1),
    .CNT_W         (4)
  ) dut0 (
    .clk (clk), .rst (rst), .start (start0), .a_o (a0), .b_o (b0), .y_i (y0),
    .busy (busy0), .done (done0), .pass (pass0), .fail_idx (fi0)
`ifdef GATE_SWEEP_ERRCNT_EN
    , .err_cnt (ec0)
`endif
  );

  gate_sweep_ctrl #(
    .SETTLE_CYCLES (1),
    .TRUTH         (4'b1000),
    .REPEAT        (3),
    .CNT_W         (4)
  ) dut1 (
    .clk (clk), .rst (rst), .start (start1), .a_o (a1), .b_o (b1), .y_i (y1),
    .busy (busy1), .done (done1), .pass (pass1), .fail_idx (fi1)
`ifdef GATE_SWEEP_ERRCNT_EN
    , .err_cnt (ec1)
`endif
  );

  logic       oa, ob, obusy, odone, opass;
  logic [1:0] ofi;
  logic [3:0] oec;

  always_comb begin
    oec = '0;
    if (sel == 1) begin
      oa = a1; ob = b1; obusy = busy1; odone = done1; opass = pass1; ofi = fi1;
`ifdef GATE_SWEEP_ERRCNT_EN
      oec = ec1;
`endif
    end else begin
      oa = a0; ob = b0; obusy = busy0; odone = done0; opass = pass0; ofi = fi0;
`ifdef GATE_SWEEP_ERRCNT_EN
      oec = ec0;
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference: sweep every vector REPEAT times against the expected table.
  function automatic void model(input logic [3:0] gtt, input int unsigned r,
                                output bit p, output logic [1:0] fi,
                                output int unsigned ec);
    logic [3:0] tt;
    int unsigned v;
    tt = EXP_TT;
    ec = 0;
    fi = 2'b00;
    for (int unsigned i = 0; i < 4 * r; i++) begin
      v = i % 4;
      if (gtt[v] != tt[v]) begin
        if (ec == 0) fi = 2'(v);
        ec++;
      end
    end
    p = (ec == 0);
    if (ec > 15) ec = 15;
  endfunction

  task automatic chk_ec(input string tag, input int unsigned eec);
`ifdef GATE_SWEEP_ERRCNT_EN
    chk(tag, oec, eec);
`else
    if (eec > 15) chk(tag, oec, 0);
`endif
  endtask

  // One run on the selected instance. Called at posedge+1; returns at posedge+1
  // of the done cycle (hold=1) or three cycles later (hold=0).
  task automatic run(input logic [3:0] gtt, input bit repulse, input bit hold);
    int unsigned s, r, len, rp, eec;
    bit          ep;
    logic [1:0]  efi, v;
    s   = (sel == 1) ? 1 : 2;
    r   = (sel == 1) ? 3 : 1;
    len = 4 * r * (s + 1);
    rp  = $urandom_range(len - 2, 1);
    model(gtt, r, ep, efi, eec);
    gate_tt = gtt;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int unsigned k = 0; k <= len; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      chk("busy_run", obusy, 1);
      chk("done_timing", odone, (k == len) ? 1 : 0);
      if (k < len) begin
        v = 2'((k / (s + 1)) % 4);
        chk("vec_a", oa, v[1]);
        chk("vec_b", ob, v[0]);
        chk("pass_low_in_run", opass, 0);
        if (k == 0) chk("fail_idx_cleared", ofi, 0);
      end else begin
        chk("a_done", oa, 0);
        chk("b_done", ob, 0);
        chk("pass", opass, ep);
        chk("fail_idx", ofi, efi);
        chk_ec("err_cnt", eec);
      end
      if (repulse && !hold) start = (k == rp);
    end
    if (!hold) begin
      for (int unsigned j = 0; j < 3; j++) begin
        if (repulse && j == 0) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after", obusy, 0);
        chk("done_once", odone, 0);
        chk("pass_held", opass, ep);
        chk("fail_idx_held", ofi, efi);
        chk_ec("err_cnt_held", eec);
      end
    end
  endtask

  initial begin
    sel     = 0;
    start   = 1'b0;
    gate_tt = 4'b1000;
    rst     = 1'b1;
    #2;
    chk("rst_a0", a0, 0);  chk("rst_b0", b0, 0);  chk("rst_busy0", busy0, 0);
    chk("rst_done0", done0, 0); chk("rst_pass0", pass0, 0); chk("rst_fi0", fi0, 0);
    chk("rst_busy1", busy1, 0); chk("rst_pass1", pass1, 0); chk("rst_fi1", fi1, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", busy0, 0);

    // Good AND gate, then OR substituted for AND.
    run(4'b1000, 1'b0, 1'b0);
    run(4'b1110, 1'b0, 1'b0);
    // Re-pulse while busy and during DONE.
    run(4'b1000, 1'b1, 1'b0);
    // start held high: next run accepted on the first IDLE edge after DONE.
    run(4'b0110, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("hold_idle_gap_busy", obusy, 0);
    chk("hold_idle_gap_done", odone, 0);
    run(4'b1000, 1'b0, 1'b0);

    // Asynchronous reset mid-run.
    gate_tt = 4'b1000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_run_b", b0, 1);
    #3 rst = 1'b1;
    #1;
    chk("abort_a", a0, 0); chk("abort_b", b0, 0); chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0); chk("abort_pass", pass0, 0); chk("abort_fi", fi0, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int unsigned j = 0; j < 14; j++) begin
      chk("no_done_after_abort", done0, 0);
      chk("idle_after_abort", busy0, 0);
      @(posedge clk); #1;
    end
    run(4'b1000, 1'b0, 1'b0);

    // REPEAT=3, SETTLE_CYCLES=1 instance.
    sel = 1;
    run(4'b1000, 1'b0, 1'b0);
    run(4'b0000, 1'b0, 1'b0);
    run(4'b0111, 1'b1, 1'b0);

    // Randomized gate tables on both instances.
    for (int unsigned i = 0; i < 8; i++) begin
      sel = int'($urandom_range(1, 0));
      run(4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
